// File: rtl/can_rx_packer.sv
// Packs a CAN receive byte stream into frame records (id, ide, dlc, 8 data bytes)
// and queues them in a small FIFO for a ready/valid consumer.
module can_rx_packer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int GAP_TIMEOUT = 4096
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    input  logic [28:0]                 rx_id,
    input  logic                        rx_ide,
    input  logic                        rx_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [28:0]                 out_id,
    output logic                        out_ide,
    output logic [3:0]                  out_dlc,
    output logic [31:0]                 out_data_lo,
    output logic [31:0]                 out_data_hi,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        overflow,
    output logic                        abort_err,
    input  logic                        flag_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic [3:0]  dlc;
        logic [63:0] data;
    } rec_t;

    state_t          state_q, state_d;
    logic            resync_q, resync_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [15:0]     gap_q, gap_d;
    logic [28:0]     id_q, id_d;
    logic            ide_q, ide_d;
    logic [7:0][7:0] bytes_q, bytes_d;
    logic            push, abort;
    rec_t            rec;

    rec_t            mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [LW-1:0]   level_q, level_d;
    logic            ovf_q, abt_q;
    logic            full, pop, wr_en, ovf_set;
    rec_t            head;

    // Frame assembly. resync_q marks that a reset may have cut a frame short:
    // stray bytes are dropped until the next rx_last realigns us.
    always_comb begin
        state_d  = state_q;
        resync_d = resync_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        id_d     = id_q;
        ide_d    = ide_q;
        bytes_d  = bytes_q;
        push     = 1'b0;
        abort    = 1'b0;
        rec      = '0;
        unique case (state_q)
            S_IDLE: begin
                gap_d = '0;
                if (rx_last) begin
                    push     = 1'b1;
                    rec.id   = rx_id;
                    rec.ide  = rx_ide;
                    if (rx_valid) begin
                        rec.dlc       = 4'd1;
                        rec.data[7:0] = rx_data;
                    end
                    resync_d = 1'b0;
                    cnt_d    = '0;
                end else if (rx_valid && !resync_q) begin
                    state_d    = S_COLLECT;
                    bytes_d    = '0;
                    bytes_d[0] = rx_data;
                    id_d       = rx_id;
                    ide_d      = rx_ide;
                    cnt_d      = 4'd1;
                end
            end
            S_COLLECT: begin
                gap_d = (rx_valid || rx_last) ? 16'd0 : gap_q + 16'd1;
                if (rx_valid && !cnt_q[3]) begin
                    bytes_d[cnt_q[2:0]] = rx_data;
                    cnt_d               = cnt_q + 4'd1;
                end
                if (rx_last) begin
                    push     = 1'b1;
                    rec.id   = id_q;
                    rec.ide  = ide_q;
                    rec.dlc  = cnt_d;
                    rec.data = bytes_d;
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                end else if (!rx_valid && gap_q == 16'(GAP_TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    gap_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign pop     = out_valid & out_ready;
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        level_d = level_q;
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q  <= S_IDLE;
            resync_q <= 1'b1;
            cnt_q    <= '0;
            gap_q    <= '0;
            id_q     <= '0;
            ide_q    <= 1'b0;
            bytes_q  <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            abt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            resync_q <= resync_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            id_q     <= id_d;
            ide_q    <= ide_d;
            bytes_q  <= bytes_d;
            level_q  <= level_d;
            if (wr_en) wr_q <= wr_q + AW'(1);
            if (pop)   rd_q <= rd_q + AW'(1);
            ovf_q    <= ovf_set | (ovf_q & ~flag_clr);
            abt_q    <= abort   | (abt_q & ~flag_clr);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (wr_en) mem_q[wr_q] <= rec;
    end

    // Outputs are gated by out_valid so reset and an empty FIFO both read as zero.
    assign head        = mem_q[rd_q];
    assign out_valid   = (level_q != '0);
    assign out_id      = out_valid ? head.id : '0;
    assign out_ide     = out_valid & head.ide;
    assign out_dlc     = out_valid ? head.dlc : '0;
    assign out_data_lo = out_valid ? head.data[31:0] : '0;
    assign out_data_hi = out_valid ? head.data[63:32] : '0;
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign abort_err   = abt_q;

endmodule

// File: tb/tb_can_rx_packer.sv
// Bench for can_rx_packer: vector table, directed corner sequences, and random
// traffic checked every cycle against a queue-based frame/FIFO model.
module tb_can_rx_packer;

    localparam int DEPTH = 4;
    localparam int GAP   = 4096;
    localparam int LW    = 3;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          rx_valid = 1'b0, rx_ide = 1'b0, rx_last = 1'b0;
    logic [7:0]    rx_data = '0;
    logic [28:0]   rx_id = '0;
    logic          out_ready = 1'b0, flag_clr = 1'b0;
    logic          out_valid, out_ide, overflow, abort_err;
    logic [28:0]   out_id;
    logic [3:0]    out_dlc;
    logic [31:0]   out_data_lo, out_data_hi;
    logic [LW-1:0] level;

    always #5 ap_clk = ~ap_clk;

    can_rx_packer #(.FIFO_DEPTH(DEPTH), .GAP_TIMEOUT(GAP)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_id(rx_id), .rx_ide(rx_ide), .rx_last(rx_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_ide(out_ide),
        .out_dlc(out_dlc), .out_data_lo(out_data_lo), .out_data_hi(out_data_hi),
        .level(level), .overflow(overflow), .abort_err(abort_err), .flag_clr(flag_clr)
    );

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic [3:0]  dlc;
        logic [63:0] data;
    } mrec_t;

    // Reference model: frames as byte lists, FIFO as a queue of records.
    bit          m_busy, m_resync, m_ovf, m_abt;
    logic [7:0]  m_bytes[$];
    logic [28:0] m_id;
    logic        m_ide;
    int          m_idle;
    mrec_t       m_fifo[$];

    int ncmp = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic mrec_t mk_rec(input logic [28:0] id, input logic ide);
        mrec_t r;
        int n;
        r = '0;
        r.id  = id;
        r.ide = ide;
        n = (m_bytes.size() > 8) ? 8 : m_bytes.size();
        r.dlc = 4'(n);
        for (int k = 0; k < n; k++) r.data[8*k +: 8] = m_bytes[k];
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_resync = 1; m_ovf = 0; m_abt = 0; m_idle = 0;
        m_bytes.delete();
        m_fifo.delete();
    endtask

    task automatic model_step();
        bit pop, have, oset, aset;
        mrec_t r;
        pop  = (m_fifo.size() > 0) && out_ready;
        have = 0; oset = 0; aset = 0; r = '0;
        if (!m_busy) begin
            if (rx_last) begin
                m_bytes.delete();
                if (rx_valid) m_bytes.push_back(rx_data);
                r = mk_rec(rx_id, rx_ide);
                have = 1;
                m_resync = 0;
            end else if (rx_valid && !m_resync) begin
                m_busy = 1;
                m_bytes.delete();
                m_bytes.push_back(rx_data);
                m_id = rx_id; m_ide = rx_ide; m_idle = 0;
            end
        end else begin
            if (rx_valid) m_bytes.push_back(rx_data);
            if (rx_last) begin
                r = mk_rec(m_id, m_ide);
                have = 1;
                m_busy = 0;
            end else if (rx_valid) begin
                m_idle = 0;
            end else begin
                m_idle++;
                if (m_idle == GAP) begin m_busy = 0; aset = 1; end
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (have) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(r);
            else oset = 1;
        end
        m_ovf = oset | (m_ovf & !flag_clr);
        m_abt = aset | (m_abt & !flag_clr);
    endtask

    task automatic check_model();
        mrec_t h;
        logic [127:0] act, exp;
        h = '0;
        if (m_fifo.size() > 0) h = m_fifo[0];
        exp = 128'({(m_fifo.size() > 0), h.id, h.ide, h.dlc, h.data, LW'(m_fifo.size()), m_ovf, m_abt});
        act = 128'({out_valid, out_id, out_ide, out_dlc, out_data_hi, out_data_lo, level, overflow, abort_err});
        chk("model", act, exp);
    endtask

    task automatic cyc();
        model_step();
        @(posedge ap_clk);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [28:0] id,
                         input logic ide, input logic last);
        rx_valid = v; rx_data = d; rx_id = id; rx_ide = ide; rx_last = last;
        cyc();
        rx_valid = 0; rx_data = '0; rx_id = '0; rx_ide = 0; rx_last = 0;
    endtask

    task automatic do_reset();
        ap_rst = 1;
        rx_valid = 0; rx_last = 0; rx_data = '0; rx_id = '0; rx_ide = 0;
        #2;
        model_reset();
        check_model();
        chk("rst_outs_zero", 128'({out_valid, out_id, out_ide, out_dlc, out_data_hi, out_data_lo,
                                   level, overflow, abort_err}), 128'(0));
        @(posedge ap_clk);
        #1;
        ap_rst = 0;
        check_model();
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [28:0] id;
        logic        ide;
        logic [3:0]  edlc;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[5];

    initial begin
        // single-cycle frames from IDLE; first one also ends the post-reset resync
        vecs[0] = '{1'b0, 8'hAA, 29'h7FF,      1'b0, 4'd0, 32'h0};
        vecs[1] = '{1'b1, 8'h5A, 29'h1FFFFFFF, 1'b1, 4'd1, 32'h5A};
        vecs[2] = '{1'b0, 8'hFF, 29'h0,        1'b0, 4'd0, 32'h0};
        vecs[3] = '{1'b1, 8'h00, 29'h123,      1'b0, 4'd1, 32'h0};
        vecs[4] = '{1'b1, 8'hC3, 29'h155AA55,  1'b1, 4'd1, 32'hC3};

        do_reset();

        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].id, vecs[i].ide, 1'b1);
            chk("vec_valid", 128'(out_valid), 128'(1));
            chk("vec_dlc",   128'(out_dlc),   128'(vecs[i].edlc));
            chk("vec_lo",    128'(out_data_lo), 128'(vecs[i].elo));
            chk("vec_hi",    128'(out_data_hi), 128'(0));
            chk("vec_id",    128'({out_id, out_ide}), 128'({vecs[i].id, vecs[i].ide}));
            out_ready = 1; cyc(); out_ready = 0;
        end

        // five-byte frame; later rx_id changes must not leak into the record
        drive(1, 8'h11, 29'h123, 0, 0);
        drive(1, 8'h22, 29'h1FFFFFFF, 1, 0);
        drive(1, 8'h33, 29'h1FFFFFFF, 1, 0);
        drive(1, 8'h44, 29'h1FFFFFFF, 1, 0);
        chk("f5_not_yet", 128'(out_valid), 128'(0));
        drive(1, 8'h55, 29'h1FFFFFFF, 1, 1);
        chk("f5_valid", 128'(out_valid), 128'(1));
        chk("f5_dlc",   128'(out_dlc), 128'(5));
        chk("f5_lo",    128'(out_data_lo), 128'(32'h44332211));
        chk("f5_hi",    128'(out_data_hi), 128'(32'h00000055));
        chk("f5_id",    128'({out_id, out_ide}), 128'({29'h123, 1'b0}));
        out_ready = 1; cyc(); out_ready = 0;

        // ten bytes saturate at eight
        for (int b = 1; b <= 10; b++) drive(1, 8'(b), 29'h42, 0, (b == 10));
        chk("f10_dlc", 128'(out_dlc), 128'(8));
        chk("f10_lo",  128'(out_data_lo), 128'(32'h04030201));
        chk("f10_hi",  128'(out_data_hi), 128'(32'h08070605));
        out_ready = 1; cyc(); out_ready = 0;
        chk("f10_drained", 128'(level), 128'(0));

        // overflow: five frames into a depth-4 FIFO with no consumer
        for (int i = 1; i <= 5; i++) drive(1, 8'(i), 29'(i), 0, 1);
        chk("ovf_level", 128'(level), 128'(4));
        chk("ovf_flag",  128'(overflow), 128'(1));
        chk("ovf_head",  128'(out_data_lo), 128'(1));
        flag_clr = 1; cyc(); flag_clr = 0;
        chk("ovf_clr", 128'(overflow), 128'(0));

        // full FIFO: push coincides with pop, so it is accepted
        out_ready = 1;
        drive(1, 8'hEE, 29'h3EE, 0, 1);
        chk("fullpop_level", 128'(level), 128'(4));
        chk("fullpop_ovf",   128'(overflow), 128'(0));
        chk("order_0", 128'(out_data_lo), 128'(2));
        cyc(); chk("order_1", 128'(out_data_lo), 128'(3));
        cyc(); chk("order_2", 128'(out_data_lo), 128'(4));
        cyc(); chk("order_3", 128'(out_data_lo), 128'(32'hEE));
        cyc(); chk("order_empty", 128'(level), 128'(0));
        out_ready = 0;

        // gap timeout boundary
        drive(1, 8'hA0, 29'h99, 0, 0);
        drive(1, 8'hA1, 29'h99, 0, 0);
        idle(GAP - 1);
        chk("gap_early", 128'(abort_err), 128'(0));
        idle(1);
        chk("gap_abort", 128'(abort_err), 128'(1));
        chk("gap_level", 128'(level), 128'(0));
        drive(0, 8'h00, 29'h0ABCDEF, 1, 1);
        chk("gap_zero_valid", 128'(out_valid), 128'(1));
        chk("gap_zero_dlc",   128'(out_dlc), 128'(0));
        chk("gap_zero_id",    128'({out_id, out_ide}), 128'({29'h0ABCDEF, 1'b1}));
        out_ready = 1; flag_clr = 1; cyc(); out_ready = 0; flag_clr = 0;
        chk("gap_clr", 128'(abort_err), 128'(0));

        // reset mid-frame with two records queued, then resync on rx_last
        drive(1, 8'hA1, 29'h1, 0, 1);
        drive(1, 8'hA2, 29'h2, 0, 1);
        chk("pre_rst_level", 128'(level), 128'(2));
        drive(1, 8'h10, 29'h5, 0, 0);
        drive(1, 8'h11, 29'h5, 0, 0);
        do_reset();
        drive(1, 8'h77, 29'h5, 0, 0);
        drive(1, 8'h78, 29'h5, 0, 0);
        chk("resync_ignored", 128'({out_valid, level}), 128'(0));
        drive(1, 8'h79, 29'h456, 1, 1);
        chk("resync_valid", 128'(out_valid), 128'(1));
        chk("resync_dlc",   128'(out_dlc), 128'(1));
        chk("resync_lo",    128'(out_data_lo), 128'(32'h79));
        chk("resync_id",    128'({out_id, out_ide}), 128'({29'h456, 1'b1}));
        out_ready = 1; cyc(); out_ready = 0;

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rx_valid  = 1'($urandom_range(0, 1));
            rx_data   = 8'($urandom);
            rx_id     = 29'($urandom);
            rx_ide    = 1'($urandom);
            rx_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flag_clr  = ($urandom_range(0, 19) == 0);
            cyc();
        end
        rx_valid = 0; rx_last = 0; out_ready = 1; flag_clr = 0;
        idle(DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
